// File: rtl/can_pkg.sv
// CAN shared definitions: field lengths, CRC-15 polynomial and the
// transmitter state enum. CAN_TX_EXT_ID_EN adds the extended-ID states.
package can_pkg;

    localparam int CAN_BASE_ID_LEN = 11;
    localparam int CAN_EXT_ID_LEN  = 18;
    localparam int CAN_DLC_LEN     = 4;
    localparam int CAN_CRC_LEN     = 15;
    localparam int CAN_EOF_LEN     = 7;

    localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

    typedef enum logic [4:0] {
        TX_IDLE,
        TX_SOF_WAIT,
        TX_SOF,
        TX_BASE_ID,
        TX_SRR_RTR,
        TX_IDE,
`ifdef CAN_TX_EXT_ID_EN
        TX_EXT_ID,
        TX_RTR,
        TX_R1,
`endif
        TX_R0,
        TX_DLC,
        TX_DATA,
        TX_CRC,
        TX_CRC_DEL,
        TX_ACK,
        TX_ACK_DEL,
        TX_EOF,
        TX_IFS
    } can_tx_state_e;

endpackage

// File: rtl/can_frame_tx_if.sv
// Frame request / status bundle of the CAN transmitter.
// master: requester (start, ident, ide, rtr, dlc, data); slave: transmitter.
interface can_frame_tx_if;

    logic        start;
    logic [28:0] ident;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        busy;
    logic        done;
    logic        arb_lost;
    logic        bit_err;
    logic        ack_err;

    modport master (
        output start, ident, ide, rtr, dlc, data,
        input  busy, done, arb_lost, bit_err, ack_err
    );

    modport slave (
        input  start, ident, ide, rtr, dlc, data,
        output busy, done, arb_lost, bit_err, ack_err
    );

endinterface

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register, MSB-first, initial value 0.
// Ports: clk, rst, clear (sync zero), shift/din (one bit in), crc[14:0].
module can_crc15
    import can_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic        din,
    output logic [14:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (shift) begin
            crc <= {crc[13:0], 1'b0} ^
                   ((din ^ crc[14]) ? CAN_CRC_POLY : 15'd0);
        end
    end

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0 frame transmitter: stuffing, CRC-15, arbitration/ACK/bit monitor.
// Ports: clk, rst, en (bit strobe), rx, tx, bus (request/status). Macro CAN_TX_EXT_ID_EN.
module can_frame_tx
    import can_pkg::*;
#(
    parameter int STUFF_LEN = 5,
    parameter int IFS_BITS  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          rx,
    output logic          tx,
    can_frame_tx_if.slave bus
);

    localparam int RUN_W = $clog2(STUFF_LEN + 1);
`ifdef CAN_TX_EXT_ID_EN
    localparam int ID_W = CAN_BASE_ID_LEN + CAN_EXT_ID_LEN;
`else
    localparam int ID_W = CAN_BASE_ID_LEN;
`endif
    localparam int IDX_W = $clog2(ID_W);

    can_tx_state_e    state, nxt_state;
    logic [6:0]       cnt, nxt_cnt, c1;
    logic [RUN_W-1:0] run;
    logic             stuff_q, armed;
    logic             nxt_bit, last;
    logic [ID_W-1:0]  id_q;
    logic             rtr_q;
    logic [3:0]       dlc_q, nbytes;
    logic [63:0]      data_q;
    logic [14:0]      crc;
    logic             crc_shift;
    logic             in_stuff, need_stuff;
    logic             arb_field, monitored;
    logic             arb_hit, ack_hit, bit_hit, abort;
`ifdef CAN_TX_EXT_ID_EN
    logic             ext_q;
`else
    localparam logic  ext_q = 1'b0;
`endif

    assign c1 = cnt + 7'd1;

    // Next field bit, as if no stuff bit were pending.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = c1;
        nxt_bit   = 1'b1;
        last      = 1'b0;
        unique case (state)
            TX_SOF_WAIT: begin
                nxt_state = TX_SOF;
                nxt_cnt   = '0;
                nxt_bit   = 1'b0;
            end
            TX_SOF: begin
                nxt_state = TX_BASE_ID;
                nxt_cnt   = '0;
                nxt_bit   = id_q[ID_W-1];
            end
            TX_BASE_ID: begin
                if (cnt == 7'(CAN_BASE_ID_LEN - 1)) begin
                    nxt_state = TX_SRR_RTR;
                    nxt_cnt   = '0;
                    // SRR is recessive in extended frames
                    nxt_bit   = ext_q | rtr_q;
                end else begin
                    nxt_bit = id_q[IDX_W'(ID_W - 1) - c1[IDX_W-1:0]];
                end
            end
            TX_SRR_RTR: begin
                nxt_state = TX_IDE;
                nxt_cnt   = '0;
                nxt_bit   = ext_q;
            end
            TX_IDE: begin
                nxt_cnt   = '0;
                nxt_state = TX_R0;
                nxt_bit   = 1'b0;
`ifdef CAN_TX_EXT_ID_EN
                if (ext_q) begin
                    nxt_state = TX_EXT_ID;
                    nxt_bit   = id_q[CAN_EXT_ID_LEN-1];
                end
            end
            TX_EXT_ID: begin
                if (cnt == 7'(CAN_EXT_ID_LEN - 1)) begin
                    nxt_state = TX_RTR;
                    nxt_cnt   = '0;
                    nxt_bit   = rtr_q;
                end else begin
                    nxt_bit = id_q[IDX_W'(CAN_EXT_ID_LEN - 1) - c1[IDX_W-1:0]];
                end
            end
            TX_RTR: begin
                nxt_state = TX_R1;
                nxt_cnt   = '0;
                nxt_bit   = 1'b0;
            end
            TX_R1: begin
                nxt_state = TX_R0;
                nxt_cnt   = '0;
                nxt_bit   = 1'b0;
`endif
            end
            TX_R0: begin
                nxt_state = TX_DLC;
                nxt_cnt   = '0;
                nxt_bit   = dlc_q[3];
            end
            TX_DLC: begin
                if (cnt == 7'(CAN_DLC_LEN - 1)) begin
                    nxt_cnt = '0;
                    if (nbytes != 4'd0) begin
                        nxt_state = TX_DATA;
                        nxt_bit   = data_q[63];
                    end else begin
                        nxt_state = TX_CRC;
                        nxt_bit   = crc[14];
                    end
                end else begin
                    nxt_bit = dlc_q[2'd3 - c1[1:0]];
                end
            end
            TX_DATA: begin
                if (c1 == {nbytes, 3'b000}) begin
                    nxt_state = TX_CRC;
                    nxt_cnt   = '0;
                    nxt_bit   = crc[14];
                end else begin
                    nxt_bit = data_q[~c1[5:0]];
                end
            end
            TX_CRC: begin
                if (cnt == 7'(CAN_CRC_LEN - 1)) begin
                    nxt_state = TX_CRC_DEL;
                    nxt_cnt   = '0;
                end else begin
                    nxt_bit = crc[4'd14 - c1[3:0]];
                end
            end
            TX_CRC_DEL: nxt_state = TX_ACK;
            TX_ACK:     nxt_state = TX_ACK_DEL;
            TX_ACK_DEL: begin
                nxt_state = TX_EOF;
                nxt_cnt   = '0;
            end
            TX_EOF: begin
                if (cnt == 7'(CAN_EOF_LEN - 1)) begin
                    nxt_state = TX_IFS;
                    nxt_cnt   = '0;
                end
            end
            TX_IFS: last = (cnt == 7'(IFS_BITS - 1));
            default: nxt_cnt = cnt;
        endcase
    end

    // The last CRC bit is never followed by a stuff bit.
    assign in_stuff   = state inside {[TX_SOF:TX_CRC]};
    assign need_stuff = in_stuff && (run == RUN_W'(STUFF_LEN)) &&
                        !(state == TX_CRC && cnt == 7'(CAN_CRC_LEN - 1));

`ifdef CAN_TX_EXT_ID_EN
    assign arb_field = state inside {TX_BASE_ID, TX_SRR_RTR, TX_IDE,
                                     TX_EXT_ID, TX_RTR};
`else
    assign arb_field = state inside {TX_BASE_ID, TX_SRR_RTR, TX_IDE};
`endif
    assign monitored = !(state inside {TX_IDLE, TX_SOF_WAIT, TX_ACK_DEL,
                                       TX_EOF, TX_IFS});

    assign arb_hit = en && arb_field && !stuff_q && tx && !rx;
    assign ack_hit = en && state == TX_ACK && rx;
    assign bit_hit = en && monitored && state != TX_ACK && !arb_hit &&
                     (rx != tx);
    assign abort   = arb_hit | ack_hit | bit_hit;

    // Stuff bits and everything from the CRC field on stay out of the CRC.
    assign crc_shift = en && !abort && !need_stuff && !last &&
                       (nxt_state inside {[TX_SOF:TX_DATA]});

    can_crc15 u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (state == TX_IDLE),
        .shift (crc_shift),
        .din   (nxt_bit),
        .crc   (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= TX_IDLE;
            cnt          <= '0;
            run          <= '0;
            stuff_q      <= 1'b0;
            armed        <= 1'b0;
            tx           <= 1'b1;
            id_q         <= '0;
            rtr_q        <= 1'b0;
            dlc_q        <= '0;
            nbytes       <= '0;
            data_q       <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.arb_lost <= 1'b0;
            bus.bit_err  <= 1'b0;
            bus.ack_err  <= 1'b0;
`ifdef CAN_TX_EXT_ID_EN
            ext_q        <= 1'b0;
`endif
        end else begin
            // armed blocks a start coincident with reset release
            armed        <= 1'b1;
            bus.done     <= 1'b0;
            bus.arb_lost <= 1'b0;
            bus.bit_err  <= 1'b0;
            bus.ack_err  <= 1'b0;
            if (state == TX_IDLE) begin
                if (armed && bus.start) begin
                    state    <= TX_SOF_WAIT;
                    cnt      <= '0;
                    run      <= '0;
                    stuff_q  <= 1'b0;
                    bus.busy <= 1'b1;
                    rtr_q    <= bus.rtr;
                    dlc_q    <= bus.dlc;
                    data_q   <= bus.data;
                    nbytes   <= bus.rtr ? 4'd0 :
                                (bus.dlc > 4'd8 ? 4'd8 : bus.dlc);
`ifdef CAN_TX_EXT_ID_EN
                    id_q     <= bus.ident;
                    ext_q    <= bus.ide;
`else
                    id_q     <= bus.ident[28:18];
`endif
                end
            end else if (en) begin
                if (abort) begin
                    state        <= TX_IDLE;
                    tx           <= 1'b1;
                    bus.busy     <= 1'b0;
                    stuff_q      <= 1'b0;
                    bus.arb_lost <= arb_hit;
                    bus.ack_err  <= ack_hit;
                    bus.bit_err  <= bit_hit;
                end else if (need_stuff) begin
                    tx      <= ~tx;
                    run     <= RUN_W'(1);
                    stuff_q <= 1'b1;
                end else if (last) begin
                    state    <= TX_IDLE;
                    tx       <= 1'b1;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end else begin
                    state   <= nxt_state;
                    cnt     <= nxt_cnt;
                    tx      <= nxt_bit;
                    stuff_q <= 1'b0;
                    run     <= (nxt_bit == tx) ? run + RUN_W'(1)
                                               : RUN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_can_frame_tx.sv
// Bench for can_frame_tx: queue-based frame model, per-bit compare process.
// Honours CAN_TX_EXT_ID_EN the same way as the design.
module tb_can_frame_tx;

    logic clk = 1'b0;
    logic rst;
    logic en = 1'b0;
    logic rx;
    logic tx;

    can_frame_tx_if bus ();

    can_frame_tx #(
        .STUFF_LEN (5),
        .IFS_BITS  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .rx  (rx),
        .tx  (tx),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, expv, $time);
        end
    endtask

    // ---------------- frame model ----------------
    bit          ubits[$];
    bit          exp_q[$];
    int          ack_pos;
    int          nstuff;
    int          destuffed_len;
    logic [14:0] model_crc;

    function automatic logic [14:0] crc_step(input logic [14:0] c,
                                             input bit b);
        return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0);
    endfunction

    task automatic build(input logic [28:0] id, input logic ide_i,
                         input logic rtr_i, input logic [3:0] dlc_i,
                         input logic [63:0] d);
        bit   ext;
        int   n;
        bit   seg[$];
        int   runl;
        bit   prev;
`ifdef CAN_TX_EXT_ID_EN
        ext = ide_i;
`else
        ext = 1'b0;
`endif
        ubits.delete();
        ubits.push_back(1'b0);
        for (int i = 28; i >= 18; i--) ubits.push_back(id[i]);
        if (ext) begin
            ubits.push_back(1'b1);
            ubits.push_back(1'b1);
            for (int i = 17; i >= 0; i--) ubits.push_back(id[i]);
            ubits.push_back(rtr_i);
            ubits.push_back(1'b0);
        end else begin
            ubits.push_back(rtr_i);
            ubits.push_back(1'b0);
        end
        ubits.push_back(1'b0);
        for (int i = 3; i >= 0; i--) ubits.push_back(dlc_i[i]);
        n = rtr_i ? 0 : (dlc_i > 8 ? 8 : int'(dlc_i));
        for (int i = 0; i < n * 8; i++) ubits.push_back(d[63 - i]);
        model_crc = '0;
        foreach (ubits[i]) model_crc = crc_step(model_crc, ubits[i]);
        seg = ubits;
        for (int i = 14; i >= 0; i--) seg.push_back(model_crc[i]);
        exp_q.delete();
        nstuff = 0;
        runl   = 0;
        prev   = 1'b1;
        foreach (seg[i]) begin
            exp_q.push_back(seg[i]);
            runl = (seg[i] == prev) ? runl + 1 : 1;
            prev = seg[i];
            if (runl == 5 && i != seg.size() - 1) begin
                exp_q.push_back(~seg[i]);
                prev = ~seg[i];
                runl = 1;
                nstuff++;
            end
        end
        exp_q.push_back(1'b1);
        ack_pos = exp_q.size();
        for (int i = 0; i < 2 + 7 + 3; i++) exp_q.push_back(1'b1);
        destuffed_len = exp_q.size() - nstuff;
    endtask

    // ---------------- bus side ----------------
    logic tracking  = 1'b0;
    logic fin       = 1'b0;
    int   n_en      = 0;
    int   end_en    = 0;
    int   cur_idx   = -1;
    int   kind      = 0;
    int   force_idx = -1;
    logic force_val = 1'b0;
    logic ack_dom   = 1'b1;
    logic busy_q    = 1'b0;
    int   div       = 0;

    always_comb begin
        rx = tx;
        if (ack_dom && cur_idx == ack_pos) rx = 1'b0;
        if (force_idx >= 0 && cur_idx == force_idx) rx = force_val;
    end

    // en is generated here so the check always sees the strobe that was
    // just consumed by the preceding rising edge.
    always @(negedge clk) begin
        if (tracking && en && busy_q) begin
            n_en++;
            if (n_en == end_en) begin
                check("end_busy", 64'(bus.busy), 64'd0);
                check("end_tx", 64'(tx), 64'd1);
                check("end_pulses",
                      64'({bus.done, bus.arb_lost, bus.bit_err, bus.ack_err}),
                      64'(4'b1000 >> kind));
                tracking = 1'b0;
                fin      = 1'b1;
                cur_idx  = -1;
            end else if (n_en - 1 < exp_q.size()) begin
                check("tx_bit", 64'(tx), 64'(exp_q[n_en-1]));
                check("busy_mid", 64'(bus.busy), 64'd1);
                check("no_pulse",
                      64'({bus.done, bus.arb_lost, bus.bit_err, bus.ack_err}),
                      64'd0);
                cur_idx = n_en - 1;
            end else begin
                check("overrun", 64'(n_en), 64'(end_en));
                tracking = 1'b0;
                fin      = 1'b1;
            end
        end
        busy_q = bus.busy;
        en     = (div == 3);
        div    = (div + 1) % 4;
    end

    task automatic launch(input logic [28:0] id, input logic ide_i,
                          input logic rtr_i, input logic [3:0] dlc_i,
                          input logic [63:0] d, input logic ackd,
                          input int fidx, input logic fval,
                          input int kind_i);
        build(id, ide_i, rtr_i, dlc_i, d);
        @(negedge clk);
        ack_dom   = ackd;
        force_idx = fidx;
        force_val = fval;
        kind      = kind_i;
        end_en    = (kind_i == 0) ? exp_q.size() + 1 :
                    (kind_i == 3) ? ack_pos + 2 : fidx + 2;
        n_en      = 0;
        fin       = 1'b0;
        cur_idx   = -1;
        bus.ident = id;
        bus.ide   = ide_i;
        bus.rtr   = rtr_i;
        bus.dlc   = dlc_i;
        bus.data  = d;
        bus.start = 1'b1;
        tracking  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_rise", 64'(bus.busy), 64'd1);
    endtask

    task automatic run(input logic [28:0] id, input logic ide_i,
                       input logic rtr_i, input logic [3:0] dlc_i,
                       input logic [63:0] d, input logic ackd,
                       input int fidx, input logic fval,
                       input int kind_i);
        launch(id, ide_i, rtr_i, dlc_i, d, ackd, fidx, fval, kind_i);
        for (int t = 0; t < 4000 && !fin; t++) @(negedge clk);
        if (!fin) begin
            check("frame_timeout", 64'(fin), 64'd1);
            tracking = 1'b0;
        end
        force_idx = -1;
        ack_dom   = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_tx", 64'(tx), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.ident = '0;
        bus.ide   = 1'b0;
        bus.rtr   = 1'b0;
        bus.dlc   = '0;
        bus.data  = '0;
        #23;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_pulses",
              64'({bus.done, bus.arb_lost, bus.bit_err, bus.ack_err}), 64'd0);

        // start coincident with reset release is ignored
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_at_rst_release", 64'(bus.busy), 64'd0);
        repeat (4) @(negedge clk);

        // model pins
        check("crc_pin1", 64'(crc_step(15'h0, 1'b1)), 64'h4599);
        check("crc_pin2", 64'(crc_step(15'h4599, 1'b0)), 64'h4EAB);

        // standard data frame
        run({11'h123, 18'h0}, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000,
            1'b1, -1, 1'b0, 0);
        check("std_destuffed_len", 64'(destuffed_len), 64'd55);

        // all-zero frame exercises stuffing
        run(29'h0, 1'b0, 1'b0, 4'd0, 64'h0, 1'b1, -1, 1'b0, 0);
        check("stuff_head",
              64'({exp_q[0], exp_q[1], exp_q[2], exp_q[3],
                   exp_q[4], exp_q[5], exp_q[6]}), 64'b0000010);
        check("zero_crc", 64'(model_crc), 64'h0);
        check("zero_len", 64'(exp_q.size()), 64'd53);

        // arbitration loss at first recessive ID bit
        run({11'h123, 18'h0}, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000,
            1'b1, 3, 1'b0, 1);
        check("arb_bit_recessive", 64'(exp_q[3]), 64'd1);

        // ACK slot left recessive
        run({11'h123, 18'h0}, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000,
            1'b0, -1, 1'b0, 3);

        // extended remote frame
        run(29'h0ABC_DE12, 1'b1, 1'b1, 4'd8, 64'hDEAD_BEEF_0123_4567,
            1'b1, -1, 1'b0, 0);
`ifdef CAN_TX_EXT_ID_EN
        check("ext_destuffed_len", 64'(destuffed_len), 64'd67);
`else
        check("ext_destuffed_len", 64'(destuffed_len), 64'd47);
`endif

        // bit error on SOF
        run({11'h3C5, 18'h0}, 1'b0, 1'b0, 4'd2, 64'h1234_0000_0000_0000,
            1'b1, 0, 1'b1, 2);

        // reset during data field
        launch({11'h555, 18'h0}, 1'b0, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF,
               1'b1, -1, 1'b0, 0);
        for (int t = 0; t < 2000 && cur_idx < 40; t++) @(negedge clk);
        check("reached_data", 64'(cur_idx >= 40), 64'd1);
        tracking = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", 64'(tx), 64'd1);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_pulses",
              64'({bus.done, bus.arb_lost, bus.bit_err, bus.ack_err}), 64'd0);
        cur_idx = -1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // frames after reset
        run({11'h7F0, 18'h0}, 1'b0, 1'b0, 4'd3, 64'hFFFF_0000_0000_0000,
            1'b1, -1, 1'b0, 0);
        run(29'h1555_AAAA, 1'b1, 1'b0, 4'd2, 64'hF00F_0000_0000_0000,
            1'b1, -1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/can_frame_tx.md
# can_frame_tx

Serial CAN 2.0 frame transmitter, the transmit-side counterpart of the packet capture block. It accepts one frame request (identifier, IDE, RTR, DLC, up to 8 data bytes) and serializes it onto `tx` one bit per `en` strobe. Serialization includes bit stuffing, CRC-15 generation, arbitration monitoring, ACK-slot checking and end-of-frame/intermission. It sits beside the receiver on the same `rx`/`tx` pins and the same bit-time strobe.

## Interface
- `STUFF_LEN`, default 5: run length of identical bits that triggers a stuff bit.
- `IFS_BITS`, default 3: recessive intermission bits after EOF before `done`.
- `clk` input 1: system clock.
- `rst` input 1: reset; **asynchronous, active-high**.
- `en` input 1: bit-time strobe, one pulse per CAN bit at the sample point. All bit-level activity advances only on cycles with `en`=1.
- `rx` input 1: bus monitor (0 = dominant).
- `tx` output 1: CAN TX line, registered (1 = recessive).
- `start` input 1: frame request. Sampled only while `busy`=0.
- `ident` input 29: `[28:18]` base ID, `[17:0]` extension. Same layout as the receiver's address, minus the IDE bit.
- `ide` input 1: extended frame request.
- `rtr` input 1: remote frame (no data field).
- `dlc` input 4: data length code. Data bytes sent = min(dlc,8), or 0 when `rtr`=1.
- `data` input 64: byte 0 in `[63:56]`, sent MSB first.
- `busy` output 1: frame latched and in progress.
- `done` output 1: one-cycle pulse on successful completion.
- `arb_lost` output 1: one-cycle pulse when arbitration is lost.
- `bit_err` output 1: one-cycle pulse when a driven bit is not read back.
- `ack_err` output 1: one-cycle pulse when the ACK slot is recessive.

## Operation
- Reset values: `tx`=1, `busy`=0, all pulse outputs 0, state IDLE, stuff counter 0, CRC 0.
- IDLE + `start`: fields are latched, `busy`=1 on the next clk, and state moves to SOF_WAIT. `start` is ignored while `busy`=1.
- Field sequence: SOF, BASE_ID(11), SRR/RTR, IDE, then EXT_ID(18), RTR, R1 if `ide`. Then R0, DLC(4), DATA(8·n), CRC(15), CRC_DEL, ACK, ACK_DEL, EOF(7), IFS(`IFS_BITS`), back to IDLE.
- Bit values in a standard frame:
  - The bit after BASE_ID is the RTR bit, then IDE=0.
  - R0=0.
- Bit values in an extended frame: SRR=1, IDE=1, RTR=`rtr`, R1=0, R0=0.
- Delimiters, ACK slot, EOF and IFS are driven recessive (1).
- Bit stuffing, SOF through the last CRC bit:
  - After `STUFF_LEN` consecutive identical bits (stuff bits included in the run), one complementary stuff bit is inserted.
  - The run counter restarts at 1 with the stuff bit.
  - Stuff bits never enter the CRC.
  - No stuffing is applied from CRC_DEL onward, including after the last CRC bit.
- CRC-15, polynomial 0x4599, initial value 0, covers destuffed SOF through the last data bit. It is shifted out MSB first.
- Monitoring happens on every `en` while `busy`. `rx` is compared with the bit currently on `tx`.
  - In arbitration fields (BASE_ID, SRR/RTR, IDE, EXT_ID, RTR) with `tx`=1 and `rx`=0: `arb_lost` pulses, `tx`=1, the block returns to IDLE and the request is dropped.
  - In the ACK slot with `rx`=1: `ack_err` pulses and the block aborts to IDLE.
  - Any other mismatch, stuff bits included: `bit_err` pulses and the block aborts to IDLE.
  - ACK_DEL through IFS mismatches are ignored.
  - Error frames are not generated.
- On any abort, `tx`=1 and `busy`=0 in the same cycle as the error pulse.

## Timing
- `busy` rises 1 clk after `start`.
- SOF is driven (`tx`=0) on the first `en` after `busy` rises.
- Each later `en`: check `rx` against the current bit, then load the next bit into `tx` on that same edge.
- `done` and the `busy` fall occur on the clk of the `en` that completes the last IFS bit.
- Unstuffed frame length: 44 bits + 8·n (standard), 64 bits + 8·n (extended), plus `IFS_BITS`.
- `rst` mid-frame: the block returns to reset values immediately, `tx` goes recessive, and no pulse is issued.
- `start` in the same cycle as `rst` deasserting is ignored.

## Configuration
- `CAN_TX_EXT_ID_EN` defined: extended frames are supported as described above.
- `CAN_TX_EXT_ID_EN` undefined:
  - `ide` and `ident[17:0]` are ignored.
  - Every frame is standard.
  - The EXT_ID, RTR and R1 states are not synthesized.

## Structure
- Package `can_pkg` holds:
  - Field-length constants (shared with the receiver).
  - `CAN_CRC_POLY`=15'h4599.
  - The transmitter state enum.
- Sub-module `can_crc15` is a serial CRC with `clk`, `rst`, `clear`, `shift`, `din` and `crc[14:0]`, reusable by the receiver's CRC check.
- Stuffing logic and bit counter stay in the top module.

## Test plan
- **Standard frame.** `ident[28:18]`=0x123, `dlc`=1, `data[63:56]`=0xA5, `rx` looped to `tx`, ACK forced dominant → 52 destuffed bits plus stuff bits match the reference model, and `done` pulses once.
- **Stuffing.** `ident`=0, `dlc`=0, loopback → `tx` sequence 0,0,0,0,0,1(stuff),0,… and the destuffed CRC matches the model.
- **Arbitration loss.** At the BASE_ID bit where `tx`=1, drive `rx`=0 → `arb_lost` pulses on that `en`, `tx`=1 from then on, `busy`=0, and no `done`.
- **ACK error.** Loopback with the ACK slot left recessive → `ack_err` pulses at the ACK bit, `busy`=0, and no `done`.
- **Extended remote frame.** `ide`=1, `rtr`=1, `dlc`=8 with the macro defined → SRR=1, IDE=1, RTR=1, no data bits, 64+3 destuffed bits. With the macro undefined, a standard frame is sent.
- **Reset mid-frame.** Assert `rst` during DATA → `tx`=1 and `busy`=0 asynchronously. A new `start` afterwards transmits a correct frame.
